exit_led_pager: RTL
===================

// Module: exit_led_pager
// PURPOSE
//  Consumes the barrel core's one-shot exit/exitcode result and pages the full
//  32-bit exit code onto the 4 board LEDs, one nibble at a time, forever.
//  Sits between the barrel instance and the led pins in the top level.
//  Replaces the direct exit/exitcode[2:0] LED mapping.
//  Frame: marker (all LEDs on), then 8 nibbles MS-first, each followed by a blank gap.
// PARAMETERS
//  DWELL_CYCLES  12_000_000  clocks each phase (marker/nibble/gap) is held; legal >= 2
//  NIBBLES       8           nibbles paged per frame (32-bit code / 4)
// PORTS
//  clk       in   1   system clock
//  resetn    in   1   asynchronous active-low reset
//  exit      in   1   core has exited; level, may stay high indefinitely
//  exitcode  in   32  exit code; valid whenever exit=1
//  led       out  4   registered LED drive
//  busy      out  1   1 once a code is captured (any state but IDLE)
// BEHAVIOUR
//  - Reset (async, resetn=0): state=IDLE, led=4'h0, busy=0, timer=0, nib_idx=NIBBLES-1,
//    code_q=0. A reset mid-frame aborts immediately; after release, wait for exit again.
//  - FSM states: IDLE, MARK, NIB, GAP.
//  - IDLE: on the first rising clk edge with exit=1, capture code_q<=exitcode,
//    go to MARK, led<=4'hF, timer<=0. led shows 4'hF in the following cycle (1-cycle latency).
//  - Every non-IDLE phase lasts exactly DWELL_CYCLES clocks.
//    timer counts 0..DWELL_CYCLES-1; the transition happens on the edge where timer==DWELL_CYCLES-1.
//    timer width $clog2(DWELL_CYCLES).
//  - MARK -> NIB with nib_idx=NIBBLES-1; led<=code_q[4*nib_idx+:4].
//  - NIB  -> GAP, led<=4'h0.
//  - GAP  -> NIB if nib_idx!=0: nib_idx decrements first, then led<=new nibble.
//  - GAP  -> MARK if nib_idx==0: led<=4'hF, nib_idx<=NIBBLES-1. Frames repeat with no limit.
//  - exit and exitcode are ignored outside IDLE. The first exit wins; the code is sticky until reset.
//    A change in exitcode mid-frame has no effect.
//  - exit deasserting after capture has no effect.
//  - busy=1 in MARK/NIB/GAP; registered, so it rises in the same cycle as led=4'hF.
//  - A nibble value of 4'hF is indistinguishable from MARK on the LEDs.
//    This is accepted; frame sync is the MARK followed by the nibble 7 position.
// CONFIGURATION
//  HEARTBEAT_EN defined:
//    In IDLE, led[0] toggles every DWELL_CYCLES clocks and led[3:1]=0.
//    The heartbeat timer is shared with the phase timer.
//    Capture still occurs on the first exit edge; led jumps straight to 4'hF.
//  HEARTBEAT_EN undefined: led=4'h0 throughout IDLE; the timer is held at 0 in IDLE.
// STRUCTURE
//  - Package exit_led_pkg:
//    typedef enum logic[1:0] {IDLE,MARK,NIB,GAP} pager_state_t;
//    localparams LED_MARK=4'hF and LED_BLANK=4'h0.
//  - Sub-module dwell_timer (param DWELL_CYCLES; ports clk, resetn, clr, done):
//    free-running count while clr=0; done=1 on the terminal count, then wraps to 0.
//    Instantiated once.
//  - FSM, nibble index and code register live in exit_led_pager.
// TESTING  (DWELL_CYCLES=4 unless noted)
//  1. Reset, exit=0 for 20 clk -> led=0, busy=0 throughout (HEARTBEAT_EN undefined).
//  2. exit=1, exitcode=32'h1234ABCD -> led: F x4, 1 x4, 0 x4, 2 x4, 0 x4, 3 ... D x4, 0 x4, then F x4.
//     busy=1 from the first F.
//  3. After capture, change exitcode to 32'hFFFFFFFF and drop exit -> paged sequence unchanged (still 1234ABCD).
//  4. Assert resetn=0 during the nibble-'A' phase -> led=0 and busy=0 asynchronously.
//     After release, exit=1 with 32'h00000007 -> F x4, 0,0 (nibble, gap) x7, then 7 x4, 0 x4.
//  5. DWELL_CYCLES=2, exitcode=32'h0 -> each phase exactly 2 clk; frame length (1+8*2)*2 = 34 clk.
//  6. HEARTBEAT_EN defined, exit=0 -> led[0] toggles every 4 clk, led[3:1]=0.
//     exit=1 mid-period -> led=4'hF on the next cycle.

Source files
------------

// File: rtl/exit_led_pkg.sv
// exit_led_pkg: shared state encoding and LED patterns for the exit-code pager.
package exit_led_pkg;
  typedef enum logic [1:0] {IDLE, MARK, NIB, GAP} pager_state_t;
  localparam logic [3:0] LED_MARK  = 4'hF;
  localparam logic [3:0] LED_BLANK = 4'h0;
endpackage

// File: rtl/dwell_timer.sv
// dwell_timer: free-running phase counter, done on terminal count then wraps; clr holds it at 0.
module dwell_timer #(
  parameter int DWELL_CYCLES = 12_000_000
) (
  input  logic clk,
  input  logic resetn,
  input  logic clr,
  output logic done
);
  localparam int W = $clog2(DWELL_CYCLES);
  localparam logic [W-1:0] LAST = W'(DWELL_CYCLES - 1);
  logic [W-1:0] cnt_q, cnt_d;
  assign done  = cnt_q == LAST;
  assign cnt_d = (clr || done) ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/exit_led_pager.sv
// exit_led_pager: pages a captured exit code onto 4 LEDs as marker, then MS-first nibbles with gaps.
// HEARTBEAT_EN: when defined, led[0] blinks in IDLE using the shared phase timer.
module exit_led_pager
  import exit_led_pkg::*;
#(
  parameter int DWELL_CYCLES = 12_000_000,
  parameter int NIBBLES      = 8
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   exit,
  input  logic [4*NIBBLES-1:0]   exitcode,
  output logic [3:0]             led,
  output logic                   busy
);
  localparam int NW = $clog2(NIBBLES);
  localparam logic [NW-1:0] NIB_TOP = NW'(NIBBLES - 1);
  pager_state_t state_q, state_d;
  logic [3:0] led_q, led_d;
  logic [NW-1:0] nib_q, nib_d, nib_dec;
  logic [4*NIBBLES-1:0] code_q, code_d;
  logic done, clr;
  assign nib_dec = nib_q - 1'b1;
`ifdef HEARTBEAT_EN
  assign clr = state_q == IDLE && exit;
`else
  assign clr = state_q == IDLE;
`endif
  dwell_timer #(.DWELL_CYCLES(DWELL_CYCLES)) u_timer (
    .clk(clk), .resetn(resetn), .clr(clr), .done(done)
  );
  always_comb begin
    state_d = state_q;
    led_d   = led_q;
    nib_d   = nib_q;
    code_d  = code_q;
    unique case (state_q)
      IDLE: begin
        if (exit) begin
          state_d = MARK;
          led_d   = LED_MARK;
          code_d  = exitcode;
          nib_d   = NIB_TOP;
        end
`ifdef HEARTBEAT_EN
        else if (done) led_d = {3'b000, ~led_q[0]};
`endif
      end
      MARK: if (done) begin
        state_d = NIB;
        nib_d   = NIB_TOP;
        led_d   = code_q[4*NIB_TOP +: 4];
      end
      NIB: if (done) begin
        state_d = GAP;
        led_d   = LED_BLANK;
      end
      GAP: if (done) begin
        state_d = nib_q == '0 ? MARK : NIB;
        nib_d   = nib_q == '0 ? NIB_TOP : nib_dec;
        led_d   = nib_q == '0 ? LED_MARK : code_q[4*nib_dec +: 4];
      end
    endcase
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state_q <= IDLE;
      led_q   <= LED_BLANK;
      nib_q   <= NIB_TOP;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      led_q   <= led_d;
      nib_q   <= nib_d;
      code_q  <= code_d;
    end
  assign led  = led_q;
  assign busy = state_q != IDLE;
endmodule
